// File: rtl/pid_ch_scheduler.sv
// rtl/pid_ch_scheduler.sv - time-multiplexed incremental PID datapath shared across N_CH loops
module pid_ch_scheduler #(
  parameter int N_CH  = 4,
  parameter int DW    = 32,
  parameter int KW    = 16,
  parameter int SHIFT = 8,
  parameter int CW    = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CW-1:0]        in_ch,
  input  logic signed [DW-1:0] target,
  input  logic signed [DW-1:0] y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_ch,
  output logic signed [DW-1:0] uk,
  input  logic                 cfg_we,
  input  logic [CW-1:0]        cfg_ch,
  input  logic [1:0]           cfg_sel,
  input  logic [KW-1:0]        cfg_data,
  input  logic [N_CH-1:0]      clr_ch
);
  // Product, three-term sum and accumulator widths; each holds its value exactly.
  localparam int PW = DW + KW + 3;
  localparam int SW = PW + 2;
  localparam int UW = SW + 1;
  localparam logic [CW:0] NCH_W = (CW+1)'(N_CH);
  localparam logic signed [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ACC, S_OUT} state_t;
  state_t state;

  logic [KW-1:0]        kp_mem [N_CH];
  logic [KW-1:0]        ki_mem [N_CH];
  logic [KW-1:0]        kd_mem [N_CH];
  logic signed [DW-1:0] e1_mem [N_CH];
  logic signed [DW-1:0] e2_mem [N_CH];
  logic signed [DW-1:0] u_mem  [N_CH];

  logic [CW-1:0]        ch_q;
  logic signed [DW-1:0] tgt_q, y_q, e0_q, e1_q, e2_q, u_q;
  logic [KW-1:0]        kp_q, ki_q, kd_q;
  logic signed [PW-1:0] p_q, i_q, d_q;

  logic                 in_ch_ok, cfg_ch_ok;
  logic signed [DW:0]   e0_wide;
  logic signed [DW-1:0] e0_sat;
  logic signed [DW+1:0] e0_x, e1_x, e2_x, de1, dd2;
  logic signed [PW-1:0] p_next, i_next, d_next;
  logic signed [SW-1:0] sum, du;
  logic signed [UW-1:0] u_wide;
  logic signed [DW-1:0] u_new;

  assign in_ch_ok  = ({1'b0, in_ch} < NCH_W);
  assign cfg_ch_ok = ({1'b0, cfg_ch} < NCH_W);

  // Datapath: saturated error, difference terms, products, increment and clamped output.
  always_comb begin
    e0_wide = {tgt_q[DW-1], tgt_q} - {y_q[DW-1], y_q};
    if (e0_wide[DW] != e0_wide[DW-1]) e0_sat = e0_wide[DW] ? DMIN : DMAX;
    else                              e0_sat = e0_wide[DW-1:0];
    e0_x   = {{2{e0_sat[DW-1]}}, e0_sat};
    e1_x   = {{2{e1_q[DW-1]}}, e1_q};
    e2_x   = {{2{e2_q[DW-1]}}, e2_q};
    de1    = e0_x - e1_x;
    dd2    = e0_x - (e1_x <<< 1) + e2_x;
    p_next = $signed({{(PW-KW){1'b0}}, kp_q}) * $signed({{(PW-DW-2){de1[DW+1]}}, de1});
    i_next = $signed({{(PW-KW){1'b0}}, ki_q}) * $signed({{(PW-DW-2){e0_x[DW+1]}}, e0_x});
    d_next = $signed({{(PW-KW){1'b0}}, kd_q}) * $signed({{(PW-DW-2){dd2[DW+1]}}, dd2});
    sum    = {{2{p_q[PW-1]}}, p_q} + {{2{i_q[PW-1]}}, i_q} + {{2{d_q[PW-1]}}, d_q};
    du     = sum >>> SHIFT;
    u_wide = {{(UW-DW){u_q[DW-1]}}, u_q} + {du[SW-1], du};
    if ((&u_wide[UW-1:DW-1]) || !(|u_wide[UW-1:DW-1])) u_new = u_wide[DW-1:0];
    else                                             u_new = u_wide[UW-1] ? DMIN : DMAX;
  end

  // Gain registers; writable in any FSM state, reserved selector and bad channel ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        kp_mem[c] <= '0;
        ki_mem[c] <= '0;
        kd_mem[c] <= '0;
      end
    end else if (cfg_we && cfg_ch_ok) begin
      case (cfg_sel)
        2'b00:   kp_mem[cfg_ch] <= cfg_data;
        2'b01:   ki_mem[cfg_ch] <= cfg_data;
        2'b10:   kd_mem[cfg_ch] <= cfg_data;
        default: ;
      endcase
    end
  end

  // Per-channel history: clear has priority over the ACC write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        e1_mem[c] <= '0;
        e2_mem[c] <= '0;
        u_mem[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (clr_ch[c]) begin
          e1_mem[c] <= '0;
          e2_mem[c] <= '0;
          u_mem[c]  <= '0;
        end else if (state == S_ACC && ch_q == CW'(c)) begin
          e2_mem[c] <= e1_q;
          e1_mem[c] <= e0_q;
          u_mem[c]  <= u_new;
        end
      end
    end
  end

  // Sample sequencer: latch, multiply, accumulate, then hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_ch    <= '0;
      uk        <= '0;
      ch_q      <= '0;
      tgt_q     <= '0;
      y_q       <= '0;
      kp_q      <= '0;
      ki_q      <= '0;
      kd_q      <= '0;
      e0_q      <= '0;
      e1_q      <= '0;
      e2_q      <= '0;
      u_q       <= '0;
      p_q       <= '0;
      i_q       <= '0;
      d_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready && in_ch_ok) begin
            ch_q     <= in_ch;
            tgt_q    <= target;
            y_q      <= y;
            kp_q     <= kp_mem[in_ch];
            ki_q     <= ki_mem[in_ch];
            kd_q     <= kd_mem[in_ch];
            e1_q     <= clr_ch[in_ch] ? '0 : e1_mem[in_ch];
            e2_q     <= clr_ch[in_ch] ? '0 : e2_mem[in_ch];
            u_q      <= clr_ch[in_ch] ? '0 : u_mem[in_ch];
            in_ready <= 1'b0;
            state    <= S_MAC;
          end
        end
        S_MAC: begin
          e0_q  <= e0_sat;
          p_q   <= p_next;
          i_q   <= i_next;
          d_q   <= d_next;
          state <= S_ACC;
        end
        S_ACC: begin
          uk        <= u_new;
          out_ch    <= ch_q;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
